lsu_ctrl: RTL and testbench

- Load/store initiator between the execute stage and the 64-bit data memory port (`ena`/`wen`/`mem_mask`/`addr`/`wdata`/`rdata`).
- Accepts one request at a time from the pipeline and drives the memory port.
- Encodes the access size into the memory's one-hot mask and places store data in its byte lane.
- Extracts, shifts and sign/zero-extends load data, then returns a response through a valid/ready handshake.

---
 rtl/lsu_ctrl_if.sv | 51 +++++
 rtl/lsu_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl_if
// Description : Bundles the three port groups of the load/store initiator:
//               the pipeline request channel (req_*), the response channel
//               (resp_*) and the 64-bit data memory port (mem_*).
//               master : the load/store unit itself (initiator on mem_*).
//               slave  : the environment (pipeline + memory).
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_ctrl_if;
  // Pipeline request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  // Response channel
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  // Data memory port
  logic        mem_ena;
  logic        mem_wen;
  logic [3:0]  mem_mask;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  modport master (
    input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem_ena, mem_wen, mem_mask, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem_ena, mem_wen, mem_mask, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store initiator between the execute stage and a 64-bit
//               data memory port. Accepts one request at a time, drives the
//               memory port for MEM_LAT+1 cycles, positions store data in its
//               byte lane, extracts/extends load data and returns it through
//               a valid/ready response.
// Ports       : clk, rst (sync, active high)
//               bus.req_*  : request in  (valid/ready, wen, size, unsigned,
//                            addr, wdata)
//               bus.resp_* : response out (valid/ready, rdata, err)
//               bus.mem_*  : memory port (ena, wen, one-hot mask, addr,
//                            wdata, rdata)
// Parameters  : MEM_LAT (0..15) extra cycles the port is held before sampling
// Options     : `define LSU_MISALIGN_TRAP_EN to trap misaligned requests with
//               resp_err instead of silently aligning the address.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
  parameter int unsigned MEM_LAT = 0
) (
  input  wire logic  clk,
  input  wire logic  rst,
  lsu_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] c_LAT = 4'(MEM_LAT);

  state_t      r_state,      w_state_nxt;
  logic [3:0]  r_cnt,        w_cnt_nxt;
  logic        r_wen,        w_wen_nxt;
  logic [1:0]  r_size,       w_size_nxt;
  logic        r_uns,        w_uns_nxt;
  logic        r_mem_ena,    w_mem_ena_nxt;
  logic        r_mem_wen,    w_mem_wen_nxt;
  logic [3:0]  r_mem_mask,   w_mem_mask_nxt;
  logic [63:0] r_mem_addr,   w_mem_addr_nxt;
  logic [63:0] r_mem_wdata,  w_mem_wdata_nxt;
  logic        r_resp_valid, w_resp_valid_nxt;
  logic [63:0] r_resp_rdata, w_resp_rdata_nxt;
  logic        r_resp_err,   w_resp_err_nxt;

  logic [2:0]  w_lowmask;
  logic [63:0] w_iss_addr;
  logic [63:0] w_lane_wdata;
  logic [63:0] w_sh;
  logic [63:0] w_ld;
  logic        w_sample;
  logic        w_trap;

  // Address bits that must be zero for a naturally aligned access.
  always_comb begin
    unique case (bus.req_size)
      2'd0:    w_lowmask = 3'b000;
      2'd1:    w_lowmask = 3'b001;
      2'd2:    w_lowmask = 3'b011;
      default: w_lowmask = 3'b111;
    endcase
  end

  // Aligned requests are unchanged; misaligned ones only reach issue in the
  // non-trapping build, where the offending low bits are dropped.
  assign w_iss_addr   = {bus.req_addr[63:3], bus.req_addr[2:0] & ~w_lowmask};
  assign w_lane_wdata = bus.req_wdata << {w_iss_addr[2:0], 3'b000};

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = |(bus.req_addr[2:0] & w_lowmask);
`else
  assign w_trap = 1'b0;
`endif

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  assign w_sh = bus.mem_rdata >> {r_mem_addr[2:0], 3'b000};

  always_comb begin
    unique case (r_size)
      2'd0:    w_ld = r_uns ? {56'd0, w_sh[7:0]}  : {{56{w_sh[7]}},  w_sh[7:0]};
      2'd1:    w_ld = r_uns ? {48'd0, w_sh[15:0]} : {{48{w_sh[15]}}, w_sh[15:0]};
      2'd2:    w_ld = r_uns ? {32'd0, w_sh[31:0]} : {{32{w_sh[31]}}, w_sh[31:0]};
      default: w_ld = w_sh;
    endcase
  end

  // The read data is captured in the last cycle the port is held.
  assign w_sample = ((r_state == ISSUE) && (MEM_LAT == 0)) ||
                    ((r_state == WAIT)  && (r_cnt == 4'd1));

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_wen_nxt        = r_wen;
    w_size_nxt       = r_size;
    w_uns_nxt        = r_uns;
    w_mem_ena_nxt    = r_mem_ena;
    w_mem_wen_nxt    = r_mem_wen;
    w_mem_mask_nxt   = r_mem_mask;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_resp_valid_nxt = r_resp_valid;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_err_nxt   = r_resp_err;

    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_wen_nxt  = bus.req_wen;
          w_size_nxt = bus.req_size;
          w_uns_nxt  = bus.req_unsigned;
          if (w_trap) begin
            // Misaligned access never touches memory.
            w_state_nxt      = RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_rdata_nxt = '0;
            w_resp_err_nxt   = 1'b1;
          end else begin
            w_state_nxt     = ISSUE;
            w_mem_ena_nxt   = 1'b1;
            w_mem_wen_nxt   = bus.req_wen;
            w_mem_mask_nxt  = 4'b1000 >> bus.req_size;
            w_mem_addr_nxt  = w_iss_addr;
            w_mem_wdata_nxt = w_lane_wdata;
          end
        end
      end
      ISSUE: begin
        w_cnt_nxt   = c_LAT;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
      end
      RESP: begin
        if (bus.resp_ready) begin
          w_resp_valid_nxt = 1'b0;
          w_state_nxt      = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Mask/addr/wdata intentionally keep their last values after release.
    if (w_sample) begin
      w_state_nxt      = RESP;
      w_mem_ena_nxt    = 1'b0;
      w_mem_wen_nxt    = 1'b0;
      w_resp_valid_nxt = 1'b1;
      w_resp_rdata_nxt = r_wen ? 64'd0 : w_ld;
      w_resp_err_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_wen        <= 1'b0;
      r_size       <= '0;
      r_uns        <= 1'b0;
      r_mem_ena    <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_mem_mask   <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_wen        <= w_wen_nxt;
      r_size       <= w_size_nxt;
      r_uns        <= w_uns_nxt;
      r_mem_ena    <= w_mem_ena_nxt;
      r_mem_wen    <= w_mem_wen_nxt;
      r_mem_mask   <= w_mem_mask_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
    end
  end

  assign bus.req_ready  = (r_state == IDLE) & ~rst;
  assign bus.mem_ena    = r_mem_ena;
  assign bus.mem_wen    = r_mem_wen;
  assign bus.mem_mask   = r_mem_mask;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  // Only ever set by the trapping build; constant zero otherwise.
  assign bus.resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Self-checking bench for lsu_ctrl. Two instances (MEM_LAT = 0
//               and MEM_LAT = 3) share request fields; per-instance valid and
//               ready are steered by sel. Directed vector table, hand-written
//               multi-cycle sequences and randomized traffic checked against
//               an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

  typedef struct packed {
    logic        err;
    logic [3:0]  mask;
    logic [63:0] maddr;
    logic [63:0] mwdata;
    logic [63:0] rdata;
  } exp_t;

  typedef struct {
    bit          s;
    bit          wen;
    logic [1:0]  size;
    bit          uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    bit          oen;
    logic [63:0] odat;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  bit          sel = 1'b0;
  logic        rv = 1'b0;
  logic        rr = 1'b0;
  logic        t_wen = 1'b0;
  logic [1:0]  t_size = 2'd0;
  logic        t_uns = 1'b0;
  logic [63:0] t_addr = 64'd0;
  logic [63:0] t_wdata = 64'd0;
  logic        ovr_en = 1'b0;
  logic [63:0] ovr = 64'd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Memory contents as a function of the doubleword address.
  function automatic logic [63:0] memfn(input logic [63:0] a);
    return {a[34:3] ^ 32'h5A3C_96E1, ~a[34:3] + 32'h1357_9BDF};
  endfunction

  lsu_ctrl_if if0 ();
  lsu_ctrl_if if3 ();

  lsu_ctrl #(.MEM_LAT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  lsu_ctrl #(.MEM_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  assign if0.req_valid    = rv & ~sel;
  assign if3.req_valid    = rv & sel;
  assign if0.resp_ready   = rr & ~sel;
  assign if3.resp_ready   = rr & sel;
  assign if0.req_wen      = t_wen;
  assign if3.req_wen      = t_wen;
  assign if0.req_size     = t_size;
  assign if3.req_size     = t_size;
  assign if0.req_unsigned = t_uns;
  assign if3.req_unsigned = t_uns;
  assign if0.req_addr     = t_addr;
  assign if3.req_addr     = t_addr;
  assign if0.req_wdata    = t_wdata;
  assign if3.req_wdata    = t_wdata;
  assign if0.mem_rdata    = ovr_en ? ovr : memfn(if0.mem_addr);
  assign if3.mem_rdata    = ovr_en ? ovr : memfn(if3.mem_addr);

  logic        s_req_ready, s_resp_valid, s_resp_err, s_mem_ena, s_mem_wen;
  logic [3:0]  s_mem_mask;
  logic [63:0] s_resp_rdata, s_mem_addr, s_mem_wdata;
  assign s_req_ready  = sel ? if3.req_ready  : if0.req_ready;
  assign s_resp_valid = sel ? if3.resp_valid : if0.resp_valid;
  assign s_resp_err   = sel ? if3.resp_err   : if0.resp_err;
  assign s_resp_rdata = sel ? if3.resp_rdata : if0.resp_rdata;
  assign s_mem_ena    = sel ? if3.mem_ena    : if0.mem_ena;
  assign s_mem_wen    = sel ? if3.mem_wen    : if0.mem_wen;
  assign s_mem_mask   = sel ? if3.mem_mask   : if0.mem_mask;
  assign s_mem_addr   = sel ? if3.mem_addr   : if0.mem_addr;
  assign s_mem_wdata  = sel ? if3.mem_wdata  : if0.mem_wdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mkexp(input bit err, input logic [3:0] mask, input logic [63:0] maddr,
                                 input logic [63:0] mwdata, input logic [63:0] rdata);
    exp_t e;
    e.err = err; e.mask = mask; e.maddr = maddr; e.mwdata = mwdata; e.rdata = rdata;
    return e;
  endfunction

  // Reference model: natural alignment, byte-lane arithmetic, extension by
  // subtracting 2^bits when the value's top bit is set.
  function automatic exp_t model(input bit wen, input logic [1:0] size, input bit uns,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input bit oen, input logic [63:0] odat);
    exp_t e;
    logic [63:0] nb, a, off, v, rd, lim;
    e  = '0;
    nb = 64'd1 << size;
`ifdef LSU_MISALIGN_TRAP_EN
    if (addr % nb != 64'd0) begin
      e.err = 1'b1;
      return e;
    end
`endif
    a        = addr - (addr % nb);
    off      = a % 64'd8;
    e.mask   = 4'b1000 >> size;
    e.maddr  = a;
    e.mwdata = wdata << (off * 64'd8);
    rd       = oen ? odat : memfn(a);
    if (!wen) begin
      v = rd >> (off * 64'd8);
      if (size != 2'd3) begin
        lim = 64'd1 << (nb * 64'd8);
        v   = v % lim;
        if (!uns && v >= lim / 64'd2) v = v - lim;
      end
      e.rdata = v;
    end
    return e;
  endfunction

  // One complete access on the selected instance; starts and ends at a negedge.
  task automatic run_txn(input bit s, input bit wen, input logic [1:0] size, input bit uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input bit oen, input logic [63:0] odat, input exp_t e,
                         input int hold, input bit busy, input string tag);
    int lat, n, ena, exp_cyc;
    lat = s ? 3 : 0;
    exp_cyc = e.err ? 0 : lat + 1;
    sel = s; t_wen = wen; t_size = size; t_uns = uns; t_addr = addr; t_wdata = wdata;
    ovr_en = oen; ovr = odat;
    rv = 1'b1;
    #1;
    n = 0;
    while (!s_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".accept"}, 64'(s_req_ready), 64'd1);
    if (!s_req_ready) begin
      rv = 1'b0;
      return;
    end
    @(negedge clk);
    rv = 1'b0;
    n = 0; ena = 0;
    while (!s_resp_valid && n < 40) begin
      if (s_mem_ena) begin
        ena++;
        chk({tag, ".mem_wen"},   64'(s_mem_wen), 64'(wen));
        chk({tag, ".mem_mask"},  64'(s_mem_mask), 64'(e.mask));
        chk({tag, ".mem_addr"},  s_mem_addr, e.maddr);
        chk({tag, ".mem_wdata"}, s_mem_wdata, e.mwdata);
      end
      @(negedge clk);
      n++;
    end
    chk({tag, ".resp_cycle"}, 64'(n), 64'(exp_cyc));
    chk({tag, ".ena_cycles"}, 64'(ena), 64'(exp_cyc));
    if (!s_resp_valid) return;
    chk({tag, ".released"}, 64'({s_mem_ena, s_mem_wen}), 64'd0);
    if (!e.err) chk({tag, ".addr_hold"}, s_mem_addr, e.maddr);
    chk({tag, ".rdata"}, s_resp_rdata, e.rdata);
    chk({tag, ".err"}, 64'(s_resp_err), 64'(e.err));
    chk({tag, ".busy_ready"}, 64'(s_req_ready), 64'd0);
    rv = busy;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_ctl"}, 64'({s_resp_valid, s_req_ready, s_resp_err}), 64'({2'b10, e.err}));
      chk({tag, ".hold_rdata"}, s_resp_rdata, e.rdata);
    end
    rr = 1'b1;
    @(negedge clk);
    rr = 1'b0;
    chk({tag, ".done"}, 64'({s_resp_valid, s_req_ready}), 64'd1);
  endtask

  vec_t vecs[$];

  task automatic add(input bit s, input bit wen, input logic [1:0] size, input bit uns,
                     input logic [63:0] addr, input logic [63:0] wdata,
                     input bit oen, input logic [63:0] odat, input exp_t e);
    vec_t v;
    v.s = s; v.wen = wen; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.oen = oen; v.odat = odat; v.e = e;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic seen;
    int   n;

    add(0, 0, 2'd0, 0, 64'h8000_0003, 64'd0, 1, 64'h0000_0000_8000_0000,
        mkexp(0, 4'b1000, 64'h8000_0003, 64'd0, 64'hFFFF_FFFF_FFFF_FF80));
    add(0, 1, 2'd1, 0, 64'h8000_0006, 64'h1234, 0, 64'd0,
        mkexp(0, 4'b0100, 64'h8000_0006, 64'h1234_0000_0000_0000, 64'd0));
    add(1, 0, 2'd2, 1, 64'h8000_0004, 64'd0, 1, 64'h8765_4321_0000_0000,
        mkexp(0, 4'b0010, 64'h8000_0004, 64'd0, 64'h0000_0000_8765_4321));
`ifdef LSU_MISALIGN_TRAP_EN
    add(1, 0, 2'd3, 0, 64'h8000_0004, 64'd0, 1, 64'h0123_4567_89AB_CDEF,
        mkexp(1, 4'b0000, 64'd0, 64'd0, 64'd0));
    add(0, 1, 2'd1, 0, 64'h1003, 64'hABCD, 0, 64'd0,
        mkexp(1, 4'b0000, 64'd0, 64'd0, 64'd0));
`else
    add(1, 0, 2'd3, 0, 64'h8000_0004, 64'd0, 1, 64'h0123_4567_89AB_CDEF,
        mkexp(0, 4'b0001, 64'h8000_0000, 64'd0, 64'h0123_4567_89AB_CDEF));
    add(0, 1, 2'd1, 0, 64'h1003, 64'hABCD, 0, 64'd0,
        mkexp(0, 4'b0100, 64'h1002, 64'h0000_0000_ABCD_0000, 64'd0));
`endif
    add(0, 0, 2'd1, 0, 64'h1000_0002, 64'd0, 1, 64'h0000_0000_8001_0000,
        mkexp(0, 4'b0100, 64'h1000_0002, 64'd0, 64'hFFFF_FFFF_FFFF_8001));
    add(0, 0, 2'd0, 1, 64'h7, 64'd0, 1, 64'hFE00_0000_0000_0000,
        mkexp(0, 4'b1000, 64'h7, 64'd0, 64'h0000_0000_0000_00FE));
    add(1, 1, 2'd3, 0, 64'h100, 64'hDEAD_BEEF_CAFE_F00D, 0, 64'd0,
        mkexp(0, 4'b0001, 64'h100, 64'hDEAD_BEEF_CAFE_F00D, 64'd0));
    add(0, 0, 2'd2, 0, 64'h20, 64'd0, 1, 64'h0000_0000_F000_0001,
        mkexp(0, 4'b0010, 64'h20, 64'd0, 64'hFFFF_FFFF_F000_0001));
    add(0, 1, 2'd0, 0, 64'h5, 64'hFFFF_FFFF_FFFF_FF5A, 0, 64'd0,
        mkexp(0, 4'b1000, 64'h5, 64'hFFFF_5A00_0000_0000, 64'd0));

    // Reset state of both instances
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst.mem_ctl", 64'({s_mem_ena, s_mem_wen, s_mem_mask}), 64'd0);
      chk("rst.mem_addr", s_mem_addr, 64'd0);
      chk("rst.mem_wdata", s_mem_wdata, 64'd0);
      chk("rst.resp_ctl", 64'({s_resp_valid, s_resp_err, s_req_ready}), 64'd0);
      chk("rst.resp_rdata", s_resp_rdata, 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ready0", 64'(if0.req_ready), 64'd1);
    chk("rst.ready3", 64'(if3.req_ready), 64'd1);

    // Directed vector table
    foreach (vecs[i])
      run_txn(vecs[i].s, vecs[i].wen, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
              vecs[i].oen, vecs[i].odat, vecs[i].e, 1, 0, $sformatf("vec%0d", i));

    // Response held back 5 cycles with a competing request pending
    e = mkexp(0, 4'b0010, 64'h8000_0004, 64'd0, 64'h0000_0000_8765_4321);
    run_txn(1, 0, 2'd2, 1, 64'h8000_0004, 64'd0, 1, 64'h8765_4321_0000_0000, e, 5, 1, "busy");
    chk("busy.accept_next", 64'(s_req_ready), 64'd1);
    e = mkexp(0, 4'b0010, 64'h8000_0010, 64'h1122_3344, 64'd0);
    run_txn(1, 1, 2'd2, 0, 64'h8000_0010, 64'h1122_3344, 0, 64'd0, e, 0, 0, "busy2");

    // Reset asserted while the MEM_LAT=3 instance is waiting
    sel = 1'b1; t_wen = 1'b0; t_size = 2'd2; t_uns = 1'b0; t_addr = 64'h40; ovr_en = 1'b0;
    rv = 1'b1;
    #1;
    n = 0;
    while (!s_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rv = 1'b0;
    chk("rstw.issue", 64'(s_mem_ena), 64'd1);
    @(negedge clk);
    chk("rstw.wait", 64'(s_mem_ena), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw.ctl", 64'({s_mem_ena, s_mem_wen, s_resp_valid, s_req_ready}), 64'd0);
    chk("rstw.addr", s_mem_addr, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstw.ready", 64'(s_req_ready), 64'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | s_resp_valid | s_mem_ena;
    end
    chk("rstw.quiet", 64'(seen), 64'd0);

    // Randomized traffic against the reference model
    for (int k = 0; k < 80; k++) begin
      bit          rs, rw, ru;
      logic [1:0]  rz;
      logic [63:0] ra, rd;
      rs = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      ru = 1'($urandom_range(0, 1));
      rz = 2'($urandom_range(0, 3));
      ra = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      e  = model(rw, rz, ru, ra, rd, 1'b0, 64'd0);
      run_txn(rs, rw, rz, ru, ra, rd, 1'b0, 64'd0, e, int'($urandom_range(0, 2)), 0,
              $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
